// File: rtl/dac_serializer.sv
// dac_serializer: one-deep ready/valid holding register feeding a
// left-justified 3-wire DAC serializer (bclk, lrck, sdata), MSB first.
//
// Ports:
//   clk           system clock, rising edge
//   n_rst         synchronous active-high reset
//   enable        serializer run request
//   sample_valid  sample_data valid this cycle
//   sample_data   {left[15:0], right[15:0]}
//   sample_ready  holding register empty
//   bclk          DAC bit clock (DIV clk cycles per half-period)
//   lrck          0 = left half-frame, 1 = right half-frame
//   sdata         serial data, updated on bclk falling edges / frame load
//   busy          1 while running
//   underrun      one-cycle pulse when a frame loads with no sample held
module dac_serializer #(
   parameter int unsigned DIV   = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        enable,
   input  logic        sample_valid,
   input  logic [31:0] sample_data,
   output logic        sample_ready,
   output logic        bclk,
   output logic        lrck,
   output logic        sdata,
   output logic        busy,
   output logic        underrun
);

   localparam int unsigned SAMPLE_W = 32;
   localparam int unsigned BIT_W    = 5;

   localparam logic [CNT_W-1:0] DIV_LAST      = CNT_W'(DIV - 1);
   localparam logic [BIT_W-1:0] LAST_BIT      = BIT_W'(SAMPLE_W - 1);
   // Bit index after which the next bit belongs to the right channel
   localparam logic [BIT_W-1:0] LEFT_LAST_BIT = BIT_W'(SAMPLE_W / 2 - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t              state, state_nxt;
   logic [SAMPLE_W-1:0] hold, hold_nxt;
   logic                hold_full, hold_full_nxt;
   logic [SAMPLE_W-1:0] shift_reg, shift_nxt;
   logic [CNT_W-1:0]    div_cnt, div_nxt;
   logic [BIT_W-1:0]    bit_cnt, bit_nxt;
   logic                bclk_nxt, lrck_nxt, sdata_nxt, busy_nxt, underrun_nxt;

   assign sample_ready = ~hold_full;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (n_rst) begin
         state     <= IDLE;
         hold      <= '0;
         hold_full <= 1'b0;
         shift_reg <= '0;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         bclk      <= 1'b0;
         lrck      <= 1'b0;
         sdata     <= 1'b0;
         busy      <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         state     <= state_nxt;
         hold      <= hold_nxt;
         hold_full <= hold_full_nxt;
         shift_reg <= shift_nxt;
         div_cnt   <= div_nxt;
         bit_cnt   <= bit_nxt;
         bclk      <= bclk_nxt;
         lrck      <= lrck_nxt;
         sdata     <= sdata_nxt;
         busy      <= busy_nxt;
         underrun  <= underrun_nxt;
      end
   end

   // Next-state, holding register and serializer datapath
   always_comb begin
      state_nxt     = state;
      hold_nxt      = hold;
      hold_full_nxt = hold_full;
      shift_nxt     = shift_reg;
      div_nxt       = div_cnt;
      bit_nxt       = bit_cnt;
      bclk_nxt      = bclk;
      lrck_nxt      = lrck;
      sdata_nxt     = sdata;
      busy_nxt      = busy;
      underrun_nxt  = 1'b0;

      // Accept only into an empty register; a later consume in this
      // cycle is impossible since consume needs the register full.
      if (sample_valid && !hold_full) begin
         hold_nxt      = sample_data;
         hold_full_nxt = 1'b1;
      end

      case (state)
         IDLE: begin
            bclk_nxt  = 1'b0;
            lrck_nxt  = 1'b0;
            sdata_nxt = 1'b0;
            busy_nxt  = 1'b0;
            if (enable && hold_full) begin
               shift_nxt     = hold;
               sdata_nxt     = hold[SAMPLE_W-1];
               bit_nxt       = '0;
               div_nxt       = '0;
               hold_full_nxt = 1'b0;
               busy_nxt      = 1'b1;
               state_nxt     = RUN;
            end
         end

         RUN: begin
            div_nxt = div_cnt + CNT_W'(1);
            if (div_cnt == DIV_LAST) begin
               div_nxt  = '0;
               bclk_nxt = ~bclk;
               // Data only moves on the falling edge; the DAC samples on the rising edge
               if (bclk) begin
                  if (bit_cnt != LAST_BIT) begin
                     bit_nxt   = bit_cnt + BIT_W'(1);
                     shift_nxt = shift_reg << 1;
                     sdata_nxt = shift_reg[SAMPLE_W-2];
                     if (bit_cnt >= LEFT_LAST_BIT) begin
                        lrck_nxt = 1'b1;
                     end
                  end else if (!enable) begin
                     state_nxt = IDLE;
                     bclk_nxt  = 1'b0;
                     lrck_nxt  = 1'b0;
                     sdata_nxt = 1'b0;
                     busy_nxt  = 1'b0;
                     bit_nxt   = '0;
                  end else if (hold_full) begin
                     shift_nxt     = hold;
                     sdata_nxt     = hold[SAMPLE_W-1];
                     lrck_nxt      = 1'b0;
                     bit_nxt       = '0;
                     hold_full_nxt = 1'b0;
                  end else begin
                     // Starved frame: send silence but keep bclk running
                     shift_nxt    = '0;
                     sdata_nxt    = 1'b0;
                     lrck_nxt     = 1'b0;
                     bit_nxt      = '0;
                     underrun_nxt = 1'b1;
                  end
               end
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dac_serializer.sv
// Self-checking bench for dac_serializer: bits captured at bclk rising
// edges are compared against frames predicted from the samples sent.
module tb_dac_serializer;

   localparam int unsigned DIV   = 2;
   localparam int unsigned FRAME = 64 * DIV;

   logic        clk = 1'b0;
   logic        n_rst = 1'b1;
   logic        enable = 1'b0;
   logic        sample_valid = 1'b0;
   logic [31:0] sample_data = '0;
   logic        sample_ready, bclk, lrck, sdata, busy, underrun;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   dac_serializer #(.DIV(DIV), .CNT_W(8)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .enable       (enable),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .sample_ready (sample_ready),
      .bclk         (bclk),
      .lrck         (lrck),
      .sdata        (sdata),
      .busy         (busy),
      .underrun     (underrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Observation of the DAC side at the falling clk edge
   logic prev_bclk = 1'b0;
   logic prev_busy = 1'b0;
   logic rb[$];
   logic rl[$];
   int   rc[$];
   int   urc[$];
   int   load_c[$];

   always @(negedge clk) begin
      if (bclk === 1'b1 && prev_bclk !== 1'b1) begin
         rb.push_back(sdata);
         rl.push_back(lrck);
         rc.push_back(cyc);
      end
      if (busy === 1'b1 && prev_busy !== 1'b1) load_c.push_back(cyc);
      if (underrun === 1'b1) urc.push_back(cyc);
      prev_bclk = bclk;
      prev_busy = busy;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic clear_mon();
      rb.delete(); rl.delete(); rc.delete(); urc.delete(); load_c.delete();
   endtask

   // Bits captured at rises base..base+31, first bit becomes the MSB
   function automatic logic [31:0] frame_word(input int base);
      logic [31:0] w = '0;
      for (int i = 0; i < 32; i++) if (base + i < rb.size()) w[31-i] = rb[base+i];
      return w;
   endfunction

   function automatic logic [31:0] lr_word(input int base);
      logic [31:0] w = '1;
      for (int i = 0; i < 32; i++) if (base + i < rl.size()) w[31-i] = rl[base+i];
      return w;
   endfunction

   task automatic do_reset();
      @(posedge clk); #1;
      n_rst = 1'b1; enable = 1'b0; sample_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 n_rst = 1'b0;
      clear_mon();
   endtask

   task automatic send(input logic [31:0] d, output int acc);
      int t = 0;
      while (sample_ready !== 1'b1 && t < 2000) begin
         @(posedge clk); #1; t++;
      end
      if (sample_ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL send_timeout: ready=%b required 1", sample_ready);
      end
      sample_valid = 1'b1;
      sample_data  = d;
      @(posedge clk); #1;
      acc = cyc;
      sample_valid = 1'b0;
   endtask

   task automatic wait_rises(input int n, input int budget);
      int t = 0;
      while (rb.size() < n && t < budget) begin
         @(posedge clk); t++;
      end
      #1;
      if (rb.size() < n) begin
         checks++; errors++;
         $display("FAIL rise_timeout: rises=%0d required %0d", rb.size(), n);
      end
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      n_rst = 1'b1; enable = 1'b1; sample_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({bclk, lrck, sdata, busy, underrun, sample_ready} !== 6'b000001) begin
         errors++;
         $display("FAIL reset_outputs: got %b required 000001",
                  {bclk, lrck, sdata, busy, underrun, sample_ready});
      end
      #1 n_rst = 1'b0;
      clear_mon();
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || rb.size() != 0 || urc.size() != 0) begin
         errors++;
         $display("FAIL idle_empty: busy=%b rises=%0d underruns=%0d required 0/0/0",
                  busy, rb.size(), urc.size());
      end
   endtask

   task automatic test_single_frame();
      int acc;
      do_reset();
      enable = 1'b1;
      send(32'hA5A5_3C3C, acc);
      checks++;
      if (sample_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_drop: got %b required 0", sample_ready);
      end
      wait_rises(32, 400);
      checks++;
      if (frame_word(0) !== 32'hA5A5_3C3C) begin
         errors++;
         $display("FAIL single_bits: got %h required a5a53c3c", frame_word(0));
      end
      checks++;
      if (lr_word(0) !== 32'h0000_FFFF) begin
         errors++;
         $display("FAIL single_lrck: got %h required 0000ffff", lr_word(0));
      end
      checks++;
      if (load_c.size() < 1 || load_c[0] != acc + 1) begin
         errors++;
         $display("FAIL load_cycle: got %0d required %0d",
                  (load_c.size() > 0) ? load_c[0] : -1, acc + 1);
      end
      checks++;
      if (load_c.size() < 1 || rc[0] - load_c[0] != DIV) begin
         errors++;
         $display("FAIL first_rise_latency: got %0d required %0d",
                  (load_c.size() > 0) ? rc[0] - load_c[0] : -1, DIV);
      end
   endtask

   task automatic test_back_to_back();
      int a1, a2, bad;
      do_reset();
      enable = 1'b1;
      send(32'h8000_0001, a1);
      send(32'h7FFF_FFFE, a2);
      checks++;
      if (load_c.size() < 1 || a2 != load_c[0] + 1) begin
         errors++;
         $display("FAIL b2b_accept: got %0d required %0d", a2,
                  (load_c.size() > 0) ? load_c[0] + 1 : -1);
      end
      wait_rises(64, 800);
      checks++;
      if (frame_word(0) !== 32'h8000_0001 || frame_word(32) !== 32'h7FFF_FFFE) begin
         errors++;
         $display("FAIL b2b_bits: got %h %h required 80000001 7ffffffe",
                  frame_word(0), frame_word(32));
      end
      bad = 0;
      for (int i = 1; i < 64 && i < rc.size(); i++) if (rc[i] - rc[i-1] != 2 * DIV) bad++;
      checks++;
      if (bad != 0 || urc.size() != 0) begin
         errors++;
         $display("FAIL b2b_gap: bad_periods=%0d underruns=%0d required 0/0", bad, urc.size());
      end
   endtask

   task automatic test_underrun();
      int acc;
      logic [31:0] s;
      do_reset();
      enable = 1'b1;
      s = $urandom;
      send(s, acc);
      wait_rises(64, 800);
      checks++;
      if (frame_word(0) !== s || frame_word(32) !== 32'h0) begin
         errors++;
         $display("FAIL underrun_bits: got %h %h required %h 00000000",
                  frame_word(0), frame_word(32), s);
      end
      checks++;
      if (rc.size() < 64 || rc[32] - rc[0] != FRAME || rc[63] - rc[32] != 31 * 2 * DIV) begin
         errors++;
         $display("FAIL frame_length: got %0d required %0d",
                  (rc.size() > 32) ? rc[32] - rc[0] : -1, FRAME);
      end
      checks++;
      if (urc.size() != 1 || load_c.size() < 1 || urc[0] != load_c[0] + FRAME) begin
         errors++;
         $display("FAIL underrun_pulse: count=%0d at=%0d required 1 at %0d", urc.size(),
                  (urc.size() > 0) ? urc[0] : -1, (load_c.size() > 0) ? load_c[0] + FRAME : -1);
      end
   endtask

   task automatic test_enable_drop();
      int acc, t;
      logic [31:0] q;
      do_reset();
      enable = 1'b1;
      send(32'hFFFF_0000, acc);
      wait_rises(6, 200);
      enable = 1'b0;
      q = $urandom;
      send(q, acc);
      t = 0;
      while (busy !== 1'b0 && t < 400) begin
         @(posedge clk); #1; t++;
      end
      checks++;
      if (busy !== 1'b0 || rb.size() != 32 || frame_word(0) !== 32'hFFFF_0000) begin
         errors++;
         $display("FAIL drop_frame: busy=%b rises=%0d bits=%h required 0/32/ffff0000",
                  busy, rb.size(), frame_word(0));
      end
      checks++;
      if ({bclk, lrck, sdata, sample_ready} !== 4'b0000) begin
         errors++;
         $display("FAIL drop_idle: got %b required 0000", {bclk, lrck, sdata, sample_ready});
      end
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (rb.size() != 32 || busy !== 1'b0 || sample_ready !== 1'b0) begin
         errors++;
         $display("FAIL drop_hold: rises=%0d busy=%b ready=%b required 32/0/0",
                  rb.size(), busy, sample_ready);
      end
      clear_mon();
      enable = 1'b1;
      wait_rises(32, 400);
      checks++;
      if (frame_word(0) !== q) begin
         errors++;
         $display("FAIL drop_resume: got %h required %h", frame_word(0), q);
      end
   endtask

   task automatic test_reset_mid_frame();
      int acc;
      logic [31:0] s3;
      do_reset();
      enable = 1'b1;
      send($urandom, acc);
      wait_rises(21, 300);
      send($urandom, acc);
      n_rst = 1'b1;
      @(posedge clk); #1;
      n_rst = 1'b0;
      checks++;
      if ({bclk, lrck, sdata, busy, underrun, sample_ready} !== 6'b000001) begin
         errors++;
         $display("FAIL midreset_outputs: got %b required 000001",
                  {bclk, lrck, sdata, busy, underrun, sample_ready});
      end
      clear_mon();
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (rb.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_discard: rises=%0d busy=%b required 0/0", rb.size(), busy);
      end
      s3 = $urandom;
      send(s3, acc);
      wait_rises(32, 400);
      checks++;
      if (frame_word(0) !== s3 || lr_word(0) !== 32'h0000_FFFF) begin
         errors++;
         $display("FAIL midreset_restart: got %h lr %h required %h lr 0000ffff",
                  frame_word(0), lr_word(0), s3);
      end
   endtask

   task automatic test_hold_no_overwrite();
      logic [31:0] dlog [0:255];
      int n = 2 + FRAME + 10;
      do_reset();
      enable = 1'b1;
      for (int k = 0; k < n; k++) begin
         sample_valid = 1'b1;
         sample_data  = $urandom;
         dlog[k]      = sample_data;
         @(posedge clk); #1;
      end
      sample_valid = 1'b0;
      wait_rises(96, 1000);
      // Accepts land on the first edge, right after the first load, and right after the next frame load
      checks++;
      if (frame_word(0) !== dlog[0] || frame_word(32) !== dlog[2] ||
          frame_word(64) !== dlog[2+FRAME]) begin
         errors++;
         $display("FAIL no_overwrite: got %h %h %h required %h %h %h",
                  frame_word(0), frame_word(32), frame_word(64),
                  dlog[0], dlog[2], dlog[2+FRAME]);
      end
      checks++;
      if (urc.size() != 0) begin
         errors++;
         $display("FAIL no_overwrite_underrun: got %0d required 0", urc.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_underrun();
      test_enable_drop();
      test_reset_mid_frame();
      test_hold_no_overwrite();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
